time_set: RTL and testbench



---
 rtl/time_set_pkg.sv | 38 +++
 rtl/time_set_if.sv | 24 ++
 rtl/time_set_bcd_merge.sv | 8 +
 rtl/time_set.sv | 130 +++++++++++++
 tb/tb_time_set.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/time_set_pkg.sv
// Shared constants and helpers for keypad time entry.
package time_set_pkg;

    localparam logic [3:0] KEY_CANCEL = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;

    localparam int TIMEOUT = 1000;
    localparam int TIMER_W = $clog2(TIMEOUT);

    localparam logic [3:0] LIMIT_H10      = 4'd2;
    localparam logic [3:0] LIMIT_H1       = 4'd9;
    localparam logic [3:0] LIMIT_H1_AT_20 = 4'd3;
    localparam logic [3:0] LIMIT_M10      = 4'd5;
    localparam logic [3:0] LIMIT_M1       = 4'd9;
    localparam logic [3:0] LIMIT_S10      = 4'd5;
    localparam logic [3:0] LIMIT_S1       = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // Largest digit allowed at a position; the hour-ones limit depends on H10.
    function automatic logic [3:0] digitLimit(input logic [2:0] pos, input logic [3:0] h10);
        logic [3:0] limit;
        case (pos)
            3'd0:    limit = LIMIT_H10;
            3'd1:    limit = (h10 == 4'd2) ? LIMIT_H1_AT_20 : LIMIT_H1;
            3'd2:    limit = LIMIT_M10;
            3'd3:    limit = LIMIT_M1;
            3'd4:    limit = LIMIT_S10;
            default: limit = LIMIT_S1;
        endcase
        return limit;
    endfunction

endpackage

// File: rtl/time_set_if.sv
// Keypad-side and counter-side signals of the time entry block.
interface time_set_if;
    logic        i_start;
    logic        i_keyValid;
    logic [3:0]  i_keyCode;
    logic [6:0]  o_setHour;
    logic [6:0]  o_setMin;
    logic [6:0]  o_setSec;
    logic        o_load;
    logic        o_busy;
    logic        o_err;
    logic [2:0]  o_digitPos;
    logic [23:0] o_entry;

    modport master (
        output i_start, i_keyValid, i_keyCode,
        input  o_setHour, o_setMin, o_setSec, o_load, o_busy, o_err, o_digitPos, o_entry
    );

    modport slave (
        input  i_start, i_keyValid, i_keyCode,
        output o_setHour, o_setMin, o_setSec, o_load, o_busy, o_err, o_digitPos, o_entry
    );
endinterface

// File: rtl/time_set_bcd_merge.sv
// Combines a BCD tens/ones pair into a 7-bit binary value (max 59).
module bcd_merge (
    input  logic [3:0] i_tens,
    input  logic [3:0] i_ones,
    output logic [6:0] o_value
);
    assign o_value = (7'(i_tens) * 7'd10) + 7'(i_ones);
endmodule

// File: rtl/time_set.sv
// Keypad time-entry FSM: collects HHMMSS digits, validates them and loads the time counter.
module time_set
    import time_set_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    time_set_if.slave  bus
);

    state_t               r_state, w_nextState;
    logic [TIMER_W-1:0]   r_timer, w_timer;
    logic [23:0]          r_entry, w_entry;
    logic [2:0]           r_digitPos, w_digitPos;
    logic [6:0]           r_setHour, r_setMin, r_setSec;
    logic [6:0]           w_setHour, w_setMin, w_setSec;
    logic                 r_load, w_load;
    logic                 r_busy, w_busy;
    logic                 r_err, w_err;
    logic [4:0]           w_shift;
    logic [6:0]           w_hourBin, w_minBin, w_secBin;

    bcd_merge u_mergeHour (.i_tens(r_entry[23:20]), .i_ones(r_entry[19:16]), .o_value(w_hourBin));
    bcd_merge u_mergeMin  (.i_tens(r_entry[15:12]), .i_ones(r_entry[11:8]),  .o_value(w_minBin));
    bcd_merge u_mergeSec  (.i_tens(r_entry[7:4]),   .i_ones(r_entry[3:0]),   .o_value(w_secBin));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_entry    <= '0;
            r_digitPos <= '0;
            r_setHour  <= '0;
            r_setMin   <= '0;
            r_setSec   <= '0;
            r_load     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_timer    <= w_timer;
            r_entry    <= w_entry;
            r_digitPos <= w_digitPos;
            r_setHour  <= w_setHour;
            r_setMin   <= w_setMin;
            r_setSec   <= w_setSec;
            r_load     <= w_load;
            r_busy     <= w_busy;
            r_err      <= w_err;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_timer     = r_timer;
        w_entry     = r_entry;
        w_digitPos  = r_digitPos;
        w_setHour   = r_setHour;
        w_setMin    = r_setMin;
        w_setSec    = r_setSec;
        w_load      = 1'b0;
        w_err       = 1'b0;
        w_shift     = {2'b00, 3'd5 - r_digitPos} << 2;

        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_nextState = ST_ENTRY;
                    w_timer     = '0;
                    w_entry     = '0;
                    w_digitPos  = '0;
                end
            end
            ST_ENTRY: begin
                // START wins over any key arriving in the same cycle.
                if (bus.i_start) begin
                    w_timer    = '0;
                    w_entry    = '0;
                    w_digitPos = '0;
                end else if (bus.i_keyValid) begin
                    w_timer = '0;
                    if (bus.i_keyCode <= 4'd9) begin
                        if (r_digitPos == 3'd6) begin
                            w_err = 1'b1;
                        end else if (bus.i_keyCode <= digitLimit(r_digitPos, r_entry[23:20])) begin
                            w_entry    = r_entry | ({20'b0, bus.i_keyCode} << w_shift);
                            w_digitPos = r_digitPos + 3'd1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end else if (bus.i_keyCode == KEY_CANCEL) begin
                        w_nextState = ST_IDLE;
                    end else if (bus.i_keyCode == KEY_ENTER) begin
                        if (r_digitPos == 3'd6) begin
                            w_nextState = ST_LOAD;
                            w_load      = 1'b1;
                            w_setHour   = w_hourBin;
                            w_setMin    = w_minBin;
                            w_setSec    = w_secBin;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end else if (r_timer == TIMER_W'(TIMEOUT - 1)) begin
                    w_err       = 1'b1;
                    w_nextState = ST_IDLE;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            ST_LOAD: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase

        w_busy = (w_nextState != ST_IDLE);
    end

    assign bus.o_setHour  = r_setHour;
    assign bus.o_setMin   = r_setMin;
    assign bus.o_setSec   = r_setSec;
    assign bus.o_load     = r_load;
    assign bus.o_busy     = r_busy;
    assign bus.o_err      = r_err;
    assign bus.o_digitPos = r_digitPos;
    assign bus.o_entry    = r_entry;

endmodule

// File: tb/tb_time_set.sv
// Directed self-checking bench for time_set.
module tb_time_set;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   waitCycles;
    bit   errSeen;

    time_set_if bus ();

    time_set dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives inputs for exactly one rising edge, returning at the following falling edge.
    task automatic applyStimulus(input logic start, input logic keyValid, input logic [3:0] keyCode);
        @(negedge clk);
        bus.i_start    = start;
        bus.i_keyValid = keyValid;
        bus.i_keyCode  = keyCode;
        @(negedge clk);
        bus.i_start    = 1'b0;
        bus.i_keyValid = 1'b0;
        bus.i_keyCode  = 4'h0;
    endtask

    task automatic pressKey(input logic [3:0] keyCode);
        applyStimulus(1'b0, 1'b1, keyCode);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_keyValid = 1'b0;
        bus.i_keyCode  = 4'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        checkOutput("rst_hour", 32'(bus.o_setHour), 32'd0);
        checkOutput("rst_load", 32'(bus.o_load), 32'd0);
        checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("rst_err", 32'(bus.o_err), 32'd0);
        checkOutput("rst_pos", 32'(bus.o_digitPos), 32'd0);
        checkOutput("rst_entry", 32'(bus.o_entry), 32'd0);

        // Full entry 12:34:56
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput("t1_busy", 32'(bus.o_busy), 32'd1);
        pressKey(4'd1);
        checkOutput("t1_pos1", 32'(bus.o_digitPos), 32'd1);
        pressKey(4'd2);
        pressKey(4'd3);
        pressKey(4'd4);
        pressKey(4'd5);
        pressKey(4'd6);
        checkOutput("t1_entry", 32'(bus.o_entry), 32'h123456);
        checkOutput("t1_pos6", 32'(bus.o_digitPos), 32'd6);
        pressKey(4'd7);
        checkOutput("t1_extra_err", 32'(bus.o_err), 32'd1);
        checkOutput("t1_extra_pos", 32'(bus.o_digitPos), 32'd6);
        pressKey(4'hB);
        checkOutput("t1_load", 32'(bus.o_load), 32'd1);
        checkOutput("t1_hour", 32'(bus.o_setHour), 32'd12);
        checkOutput("t1_min", 32'(bus.o_setMin), 32'd34);
        checkOutput("t1_sec", 32'(bus.o_setSec), 32'd56);
        checkOutput("t1_busy_load", 32'(bus.o_busy), 32'd1);
        @(negedge clk);
        checkOutput("t1_load_end", 32'(bus.o_load), 32'd0);
        checkOutput("t1_busy_end", 32'(bus.o_busy), 32'd0);
        pressKey(4'd5);
        checkOutput("idle_key_pos", 32'(bus.o_digitPos), 32'd6);
        checkOutput("idle_key_busy", 32'(bus.o_busy), 32'd0);

        // Hour limit when H10 is 2
        applyStimulus(1'b1, 1'b0, 4'h0);
        pressKey(4'd2);
        pressKey(4'd4);
        checkOutput("t2_err", 32'(bus.o_err), 32'd1);
        checkOutput("t2_pos", 32'(bus.o_digitPos), 32'd1);
        pressKey(4'd3);
        checkOutput("t2_err_clear", 32'(bus.o_err), 32'd0);
        checkOutput("t2_hour_bcd", 32'(bus.o_entry[23:16]), 32'h23);
        pressKey(4'hA);
        checkOutput("t2_cancel_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("t2_cancel_err", 32'(bus.o_err), 32'd0);

        // Minute tens limit, then 09:59:59
        applyStimulus(1'b1, 1'b0, 4'h0);
        pressKey(4'd0);
        pressKey(4'd9);
        pressKey(4'd6);
        checkOutput("t3_err", 32'(bus.o_err), 32'd1);
        checkOutput("t3_pos", 32'(bus.o_digitPos), 32'd2);
        pressKey(4'd5);
        pressKey(4'd9);
        pressKey(4'd5);
        pressKey(4'd9);
        pressKey(4'hB);
        checkOutput("t3_load", 32'(bus.o_load), 32'd1);
        checkOutput("t3_hour", 32'(bus.o_setHour), 32'd9);
        checkOutput("t3_min", 32'(bus.o_setMin), 32'd59);
        checkOutput("t3_sec", 32'(bus.o_setSec), 32'd59);

        // Early enter then cancel keeps previous SET values
        applyStimulus(1'b1, 1'b0, 4'h0);
        pressKey(4'd1);
        pressKey(4'd2);
        pressKey(4'd3);
        pressKey(4'hB);
        checkOutput("t4_err", 32'(bus.o_err), 32'd1);
        checkOutput("t4_load", 32'(bus.o_load), 32'd0);
        checkOutput("t4_busy", 32'(bus.o_busy), 32'd1);
        pressKey(4'hA);
        checkOutput("t4_cancel_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("t4_hour", 32'(bus.o_setHour), 32'd9);
        checkOutput("t4_min", 32'(bus.o_setMin), 32'd59);
        checkOutput("t4_sec", 32'(bus.o_setSec), 32'd59);

        // Timeout after 1000 idle entry cycles
        applyStimulus(1'b1, 1'b0, 4'h0);
        waitCycles = 0;
        errSeen    = 1'b0;
        while (!errSeen && waitCycles < 1100) begin
            @(negedge clk);
            waitCycles++;
            if (bus.o_err === 1'b1) errSeen = 1'b1;
        end
        checkOutput("t5_err_seen", 32'(errSeen), 32'd1);
        checkOutput("t5_cycles", 32'(waitCycles), 32'd1000);
        checkOutput("t5_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("t5_load", 32'(bus.o_load), 32'd0);
        @(negedge clk);
        checkOutput("t5_err_pulse", 32'(bus.o_err), 32'd0);
        checkOutput("t5_sec_kept", 32'(bus.o_setSec), 32'd59);

        // Reset mid-entry
        applyStimulus(1'b1, 1'b0, 4'h0);
        pressKey(4'd1);
        pressKey(4'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("t5r_hour", 32'(bus.o_setHour), 32'd0);
        checkOutput("t5r_min", 32'(bus.o_setMin), 32'd0);
        checkOutput("t5r_entry", 32'(bus.o_entry), 32'd0);
        checkOutput("t5r_pos", 32'(bus.o_digitPos), 32'd0);
        checkOutput("t5r_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("t5r_err", 32'(bus.o_err), 32'd0);
        checkOutput("t5r_load", 32'(bus.o_load), 32'd0);

        // START with a simultaneous key restarts and drops the key
        applyStimulus(1'b1, 1'b0, 4'h0);
        pressKey(4'd1);
        pressKey(4'd2);
        pressKey(4'd3);
        pressKey(4'd4);
        checkOutput("t6_pos4", 32'(bus.o_digitPos), 32'd4);
        applyStimulus(1'b1, 1'b1, 4'd5);
        checkOutput("t6_pos", 32'(bus.o_digitPos), 32'd0);
        checkOutput("t6_entry", 32'(bus.o_entry), 32'd0);
        checkOutput("t6_busy", 32'(bus.o_busy), 32'd1);
        pressKey(4'd2);
        checkOutput("t6_fresh", 32'(bus.o_entry), 32'h200000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
